// File: rtl/cnn_frame_sequencer.sv
// Gates a first-word-fall-through pixel FIFO into the CNN one frame at a time.
// Each frame ends with a held digit (or timeout marker) that must be accepted before the next frame streams.
module cnn_frame_sequencer #(
    parameter int GS_BITS        = 8,
    parameter int BCD_BITS       = 4,
    parameter int IMG_DIM        = 30,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                fifo_empty_i,
    input  logic [GS_BITS-1:0]  fifo_dout_i,
    output logic                fifo_rd_en_o,
    output logic [GS_BITS-1:0]  pixel_o,
    output logic                pixel_valid_o,
    input  logic [BCD_BITS-1:0] digit_i,
    input  logic                digit_valid_i,
    output logic [BCD_BITS-1:0] result_o,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic                timeout_o,
    output logic                spurious_o,
    output logic                busy_o,
    output logic [15:0]         frame_cnt_o
);

    localparam int NPIX  = IMG_DIM * IMG_DIM;
    localparam int PIX_W = $clog2(NPIX);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        STREAM,
        WAIT_RESULT,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PIX_W-1:0] pix_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STREAM;
        end else begin
            state <= state_next;
        end
    end

    // Pixel release is only possible in STREAM, and never while reset is held.
    always_comb begin
        state_next = state;
        fire       = 1'b0;
        case (state)
            STREAM: begin
                fire = start_i & ~fifo_empty_i;
                if (fire && pix_cnt == PIX_LAST) begin
                    state_next = WAIT_RESULT;
                end
            end
            WAIT_RESULT: begin
                if (digit_valid_i || to_cnt == TO_LAST) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (result_ready_i) begin
                    state_next = STREAM;
                end
            end
            default: state_next = STREAM;
        endcase
        if (rst) begin
            fire = 1'b0;
        end
    end

    assign fifo_rd_en_o  = fire;
    assign pixel_valid_o = fire;
    assign pixel_o       = fifo_dout_i;
    assign busy_o        = (state != STREAM) || (pix_cnt != '0);

    // A real digit on the final timeout cycle takes priority over the timeout marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt        <= '0;
            to_cnt         <= '0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            timeout_o      <= 1'b0;
            spurious_o     <= 1'b0;
            frame_cnt_o    <= '0;
        end else begin
            if (digit_valid_i && state != WAIT_RESULT) begin
                spurious_o <= 1'b1;
            end
            case (state)
                STREAM: begin
                    if (fire) begin
                        if (pix_cnt == PIX_LAST) begin
                            pix_cnt <= '0;
                            to_cnt  <= '0;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                end
                WAIT_RESULT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (digit_valid_i) begin
                        result_o       <= digit_i;
                        timeout_o      <= 1'b0;
                        result_valid_o <= 1'b1;
                    end else if (to_cnt == TO_LAST) begin
                        result_o       <= {BCD_BITS{1'b1}};
                        timeout_o      <= 1'b1;
                        result_valid_o <= 1'b1;
                    end
                end
                HOLD: begin
                    if (result_ready_i) begin
                        result_valid_o <= 1'b0;
                        frame_cnt_o    <= frame_cnt_o + 16'd1;
                        pix_cnt        <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed bench for cnn_frame_sequencer: 30x30 frames, 16-cycle result timeout,
// behavioural FWFT FIFO whose pixel values are a known function of their global index.
module tb_cnn_frame_sequencer;

    localparam int NPIX = 900;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        fifo_empty_i;
    logic [7:0]  fifo_dout_i;
    logic        fifo_rd_en_o;
    logic [7:0]  pixel_o;
    logic        pixel_valid_o;
    logic [3:0]  digit_i = 4'd0;
    logic        digit_valid_i = 1'b0;
    logic [3:0]  result_o;
    logic        result_valid_o;
    logic        result_ready_i = 1'b0;
    logic        timeout_o;
    logic        spurious_o;
    logic        busy_o;
    logic [15:0] frame_cnt_o;

    logic [7:0]  mem [4096];
    int          rd_ptr = 0;
    int          wr_ptr = 0;
    logic        gate_empty = 1'b0;
    int          exp_idx = 0;
    int          tests = 0;
    int          errors = 0;

    cnn_frame_sequencer #(
        .GS_BITS(8), .BCD_BITS(4), .IMG_DIM(30), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .fifo_empty_i(fifo_empty_i), .fifo_dout_i(fifo_dout_i), .fifo_rd_en_o(fifo_rd_en_o),
        .pixel_o(pixel_o), .pixel_valid_o(pixel_valid_o),
        .digit_i(digit_i), .digit_valid_i(digit_valid_i),
        .result_o(result_o), .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .timeout_o(timeout_o), .spurious_o(spurious_o), .busy_o(busy_o), .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    assign fifo_empty_i = gate_empty || (rd_ptr == wr_ptr);
    assign fifo_dout_i  = mem[rd_ptr % 4096];

    always @(posedge clk) begin
        if (fifo_rd_en_o && rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;
    end

    function automatic logic [7:0] pix(input int i);
        return 8'((i * 37 + 11) ^ (i >> 7));
    endfunction

    typedef struct {
        logic        rst;
        logic        start;
        logic        dv;
        logic [3:0]  digit;
        logic        ready;
        logic        exp_rv;
        logic [3:0]  exp_res;
        logic        exp_to;
        logic        exp_sp;
        logic        exp_busy;
        logic        exp_rd;
        logic [15:0] exp_fc;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst            = v.rst;
        start_i        = v.start;
        digit_valid_i  = v.dv;
        digit_i        = v.digit;
        result_ready_i = v.ready;
        step();
    endtask

    task automatic loadPixels(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 4096] = pix(wr_ptr);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    // Streams until n pixels fire; optional empty toggling, a 10-cycle start_i pause and a stray digit pulse.
    task automatic streamPixels(input int n, input bit toggle, input int pause_at, input int spur_at);
        int fired = 0;
        int cyc = 0;
        int bad_val = 0;
        int bad_rd = 0;
        int paused = 0;
        bit spur_done = 1'b0;
        while (fired < n && cyc < 8000) begin
            gate_empty    = toggle ? cyc[0] : 1'b0;
            start_i       = 1'b1;
            digit_valid_i = 1'b0;
            if (pause_at >= 0 && fired >= pause_at && paused < 10) begin
                start_i = 1'b0;
                paused++;
            end
            if (spur_at >= 0 && fired == spur_at && !spur_done) begin
                digit_valid_i = 1'b1;
                digit_i       = 4'd9;
                spur_done     = 1'b1;
            end
            #1;
            if (fifo_rd_en_o !== pixel_valid_o) bad_rd++;
            if (pixel_valid_o === 1'b1) begin
                if (pixel_o !== pix(exp_idx)) bad_val++;
                exp_idx++;
                fired++;
            end
            step();
            cyc++;
        end
        gate_empty    = 1'b0;
        digit_valid_i = 1'b0;
        checkOutput("stream_count", fired, n);
        checkOutput("stream_pixel_values", bad_val, 0);
        checkOutput("stream_rd_en_eq_valid", bad_rd, 0);
        if (pause_at >= 0) checkOutput("stream_pause_taken", paused, 10);
    endtask

    task automatic waitResult();
        int cyc = 0;
        int bad_rd = 0;
        while (result_valid_o !== 1'b1 && cyc < 100) begin
            #1;
            if (fifo_rd_en_o !== 1'b0) bad_rd++;
            step();
            cyc++;
        end
        checkOutput("wait_result_reached", result_valid_o, 1'b1);
        checkOutput("wait_no_rd_en", bad_rd, 0);
    endtask

    task automatic acceptResult();
        result_ready_i = 1'b1;
        #1;
        checkOutput("accept_cycle_no_rd_en", fifo_rd_en_o, 1'b0);
        step();
        result_ready_i = 1'b0;
        checkOutput("accept_clears_valid", result_valid_o, 1'b0);
    endtask

    initial begin
        bit early;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};

        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i),
                {result_valid_o, result_o, timeout_o, spurious_o, busy_o, fifo_rd_en_o, frame_cnt_o},
                {vecs[i].exp_rv, vecs[i].exp_res, vecs[i].exp_to, vecs[i].exp_sp,
                 vecs[i].exp_busy, vecs[i].exp_rd, vecs[i].exp_fc});
        end
        result_ready_i = 1'b0;

        // Full frame followed by a digit; an extra pixel waits in the FIFO to expose early release.
        loadPixels(NPIX + 1);
        streamPixels(NPIX, 1'b0, -1, -1);
        #1;
        checkOutput("t1_rd_en_after_frame", fifo_rd_en_o, 1'b0);
        checkOutput("t1_busy_in_wait", busy_o, 1'b1);
        for (int i = 0; i < 10; i++) step();
        checkOutput("t2_no_result_yet", result_valid_o, 1'b0);
        digit_valid_i = 1'b1;
        digit_i       = 4'd7;
        step();
        digit_valid_i = 1'b0;
        digit_i       = 4'd0;
        checkOutput("t2_result", {result_valid_o, result_o, timeout_o}, {1'b1, 4'd7, 1'b0});
        for (int i = 0; i < 3; i++) step();
        checkOutput("t2_result_stable", {result_valid_o, result_o, timeout_o, fifo_rd_en_o},
                    {1'b1, 4'd7, 1'b0, 1'b0});
        acceptResult();
        checkOutput("t2_frame_cnt", frame_cnt_o, 16'd1);
        #1;
        checkOutput("t2_fire_after_accept", fifo_rd_en_o, 1'b1);

        // Two frames with a bursty FIFO and a start_i pause; both end by timeout.
        loadPixels(2 * NPIX - 1);
        streamPixels(NPIX, 1'b1, 450, -1);
        waitResult();
        checkOutput("t3_timeout_marker", {result_o, timeout_o}, {4'hF, 1'b1});
        acceptResult();
        streamPixels(NPIX, 1'b1, -1, -1);
        waitResult();
        acceptResult();
        checkOutput("t3_frame_cnt", frame_cnt_o, 16'd3);

        // Timeout lands exactly 16 cycles after the last pixel.
        loadPixels(NPIX);
        streamPixels(NPIX, 1'b0, -1, -1);
        early = 1'b0;
        for (int k = 1; k < 16; k++) begin
            step();
            if (result_valid_o !== 1'b0) early = 1'b1;
        end
        checkOutput("t4_no_early_timeout", early, 1'b0);
        step();
        checkOutput("t4_timeout", {result_valid_o, result_o, timeout_o}, {1'b1, 4'hF, 1'b1});
        acceptResult();

        // Digit arriving on the terminal timeout cycle beats the timeout.
        loadPixels(NPIX);
        streamPixels(NPIX, 1'b0, -1, -1);
        for (int k = 0; k < 15; k++) step();
        digit_valid_i = 1'b1;
        digit_i       = 4'd3;
        step();
        digit_valid_i = 1'b0;
        checkOutput("t4_digit_wins", {result_valid_o, result_o, timeout_o}, {1'b1, 4'd3, 1'b0});
        acceptResult();
        checkOutput("t4_frame_cnt", frame_cnt_o, 16'd5);
        checkOutput("t4_no_spurious", spurious_o, 1'b0);

        // Stray digit pulse mid-stream sets the sticky flag without disturbing the frame.
        loadPixels(NPIX);
        streamPixels(NPIX, 1'b0, -1, 100);
        checkOutput("t5_spurious_set", spurious_o, 1'b1);
        waitResult();
        checkOutput("t5_result_is_timeout", {result_o, timeout_o}, {4'hF, 1'b1});
        acceptResult();
        checkOutput("t5_spurious_sticky", spurious_o, 1'b1);
        checkOutput("t5_frame_cnt", frame_cnt_o, 16'd6);

        // Reset halfway through a frame; the FIFO keeps the remaining pixels.
        loadPixels(NPIX + 1);
        streamPixels(450, 1'b0, -1, -1);
        rst = 1'b1;
        #1;
        checkOutput("t6_rd_en_in_reset", {fifo_rd_en_o, pixel_valid_o}, 2'b00);
        step();
        rst = 1'b0;
        checkOutput("t6_reset_outputs",
            {result_valid_o, result_o, timeout_o, spurious_o, busy_o, frame_cnt_o},
            {1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'd0});
        loadPixels(450);
        streamPixels(NPIX, 1'b0, -1, -1);
        #1;
        checkOutput("t6_fresh_frame_end", {fifo_rd_en_o, busy_o, result_valid_o}, {1'b0, 1'b1, 1'b0});
        waitResult();
        acceptResult();
        checkOutput("t6_frame_cnt", frame_cnt_o, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
